// File: rtl/fifo_frame_arbiter.sv
// Round-robin arbiter sharing one FIFO_RAM read port among NUM_REQ consumers; 1-cycle registered forwarding.
// Optional frame-length checking is enabled with `define FRAME_CHECK_EN (len_err tied 0 otherwise).
module fifo_frame_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  output logic [NUM_REQ-1:0]    gnt,
  output logic                  busy,
  output logic                  fifo_request,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_valid,
  input  logic                  fifo_tlast,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [NUM_REQ-1:0]    out_valid,
  output logic                  out_tlast,
  output logic                  timeout_err,
  output logic                  len_err
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT - 1);
  localparam logic [PW-1:0] IDX_MAX = PW'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_XFER} state_t;

  state_t              r_state, w_state_nxt;
  logic [PW-1:0]       r_ptr, r_idx, w_pick;
  logic                w_found;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [TW-1:0]       r_to_cnt;
  logic                w_fwd, w_done, w_abort, w_release;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [NUM_REQ-1:0]  r_out_valid;
  logic                r_out_tlast, r_timeout_err;

  // First requester at or above the rotating pointer, wrapping at NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = int'(r_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!w_found && req[j]) begin
        w_found = 1'b1;
        w_pick  = PW'(j);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fwd       = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: if (w_found) w_state_nxt = S_REQ;
      S_REQ:  w_state_nxt = S_WAIT;
      S_WAIT, S_XFER: begin
        w_fwd = fifo_valid;
        // A valid beat clears the idle counter, so tlast always beats the timeout.
        if (fifo_valid && fifo_tlast) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (fifo_valid) begin
          w_state_nxt = S_XFER;
        end else if (r_to_cnt == TO_MAX) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_release = w_done | w_abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_idx         <= '0;
      r_gnt         <= '0;
      r_to_cnt      <= '0;
      r_out_data    <= '0;
      r_out_valid   <= '0;
      r_out_tlast   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_found) begin
        r_gnt <= NUM_REQ'(1) << w_pick;
        r_idx <= w_pick;
      end else if (w_release) begin
        r_gnt <= '0;
        r_ptr <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
      end
      if (r_state == S_REQ || w_fwd)
        r_to_cnt <= '0;
      else if (r_state == S_WAIT || r_state == S_XFER)
        r_to_cnt <= r_to_cnt + 1'b1;
      r_out_valid   <= w_fwd ? r_gnt : '0;
      r_out_tlast   <= w_fwd & fifo_tlast;
      r_timeout_err <= w_abort;
      if (w_fwd) r_out_data <= fifo_data;
    end
  end

`ifdef FRAME_CHECK_EN
  localparam int BW = $clog2(FRAME_LEN + 1);
  localparam logic [BW-1:0] LEN_EXP = BW'(FRAME_LEN);

  logic [BW-1:0] r_beat_cnt, w_beat_inc;
  logic          r_len_err;

  assign w_beat_inc = (&r_beat_cnt) ? r_beat_cnt : r_beat_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
      r_len_err  <= 1'b0;
    end else begin
      r_len_err <= 1'b0;
      if (r_state == S_IDLE) begin
        r_beat_cnt <= '0;
      end else if (w_fwd) begin
        r_beat_cnt <= w_beat_inc;
        if (fifo_tlast) r_len_err <= (w_beat_inc != LEN_EXP);
        else            r_len_err <= (w_beat_inc == LEN_EXP);
      end
    end
  end

  assign len_err = r_len_err;
`else
  assign len_err = 1'b0;
`endif

  assign gnt          = r_gnt;
  assign busy         = (r_state != S_IDLE);
  assign fifo_request = (r_state == S_REQ);
  assign out_data     = r_out_data;
  assign out_valid    = r_out_valid;
  assign out_tlast    = r_out_tlast;
  assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_fifo_frame_arbiter.sv
// Directed bench for fifo_frame_arbiter: reset, single frame, round-robin, timeout, stray beats, length check.
module tb_fifo_frame_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic        busy, fifo_request;
  logic [31:0] fifo_data;
  logic        fifo_valid, fifo_tlast;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic        out_tlast, timeout_err, len_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_frame_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(32), .FRAME_LEN(32), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .busy(busy),
    .fifo_request(fifo_request), .fifo_data(fifo_data), .fifo_valid(fifo_valid),
    .fifo_tlast(fifo_tlast), .out_data(out_data), .out_valid(out_valid),
    .out_tlast(out_tlast), .timeout_err(timeout_err), .len_err(len_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Grant from IDLE, then stream nbeats beats with tlast on the last one.
  task automatic grant_frame(input string tag, input logic [3:0] req_vec,
                             input logic [3:0] req_after, input logic [3:0] exp_gnt,
                             input int nbeats);
    logic exp_len;
    req = req_vec;
    step();
    check({tag, " gnt"}, 32'(gnt), 32'(exp_gnt));
    check({tag, " fifo_request"}, 32'(fifo_request), 32'd1);
    check({tag, " idle out_valid"}, 32'(out_valid), 32'd0);
    req = req_after;
    step();
    check({tag, " request pulse end"}, 32'(fifo_request), 32'd0);
    for (int b = 1; b <= nbeats; b++) begin
      fifo_valid = 1'b1;
      fifo_data  = 32'hD000_0000 + 32'(b);
      fifo_tlast = (b == nbeats);
      step();
`ifdef FRAME_CHECK_EN
      exp_len = (b == nbeats) ? (b != 32) : (b == 32);
`else
      exp_len = 1'b0;
`endif
      check({tag, " out_valid"}, 32'(out_valid), 32'(exp_gnt));
      check({tag, " out_data"}, out_data, 32'hD000_0000 + 32'(b));
      check({tag, " out_tlast"}, 32'(out_tlast), 32'(b == nbeats));
      check({tag, " len_err"}, 32'(len_err), 32'(exp_len));
      check({tag, " no extra request"}, 32'(fifo_request), 32'd0);
    end
    fifo_valid = 1'b0;
    fifo_tlast = 1'b0;
    check({tag, " released gnt"}, 32'(gnt), 32'd0);
    check({tag, " released busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req = '0; fifo_data = '0; fifo_valid = 1'b0; fifo_tlast = 1'b0;
    step(); step();
    check("reset gnt", 32'(gnt), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset fifo_request", 32'(fifo_request), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", out_data, 32'd0);
    check("reset out_tlast", 32'(out_tlast), 32'd0);
    check("reset timeout_err", 32'(timeout_err), 32'd0);
    check("reset len_err", 32'(len_err), 32'd0);
    rst_n = 1'b1;
    step();

    // Stray beats while IDLE are dropped.
    fifo_valid = 1'b1; fifo_data = 32'hAAAA_5555; fifo_tlast = 1'b1;
    step(); step();
    check("stray out_valid", 32'(out_valid), 32'd0);
    check("stray out_tlast", 32'(out_tlast), 32'd0);
    check("stray out_data", out_data, 32'd0);
    check("stray busy", 32'(busy), 32'd0);
    fifo_valid = 1'b0; fifo_tlast = 1'b0;

    grant_frame("single", 4'b0100, 4'b0000, 4'b0100, 32);
    step();
    check("single trailing out_valid", 32'(out_valid), 32'd0);

    // Pointer now sits at 3; requester 1 is reached by wrapping.
    req = 4'b0010;
    step();
    check("rst-frame gnt", 32'(gnt), 32'b0010);
    req = 4'b0000;
    step();
    for (int b = 1; b <= 3; b++) begin
      fifo_valid = 1'b1; fifo_data = 32'hC000_0000 + 32'(b);
      step();
    end
    check("rst-frame mid out_valid", 32'(out_valid), 32'b0010);
    #2 rst_n = 1'b0;
    #1;
    check("mid reset gnt", 32'(gnt), 32'd0);
    check("mid reset busy", 32'(busy), 32'd0);
    check("mid reset out_valid", 32'(out_valid), 32'd0);
    check("mid reset out_data", out_data, 32'd0);
    check("mid reset fifo_request", 32'(fifo_request), 32'd0);
    fifo_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    grant_frame("rr0", 4'b1111, 4'b1111, 4'b0001, 4);
    grant_frame("rr1", 4'b1111, 4'b1111, 4'b0010, 4);
    grant_frame("rr2", 4'b1111, 4'b1111, 4'b0100, 4);
    grant_frame("rr3", 4'b1111, 4'b1111, 4'b1000, 4);
    grant_frame("rr4", 4'b1111, 4'b0000, 4'b0001, 4);

    // Timeout: pointer at 1, no data ever arrives.
    req = 4'b0010;
    step();
    check("timeout gnt", 32'(gnt), 32'b0010);
    req = 4'b0000;
    step();
    for (int k = 1; k <= 15; k++) begin
      step();
      check("timeout early", 32'(timeout_err), 32'd0);
    end
    check("timeout gnt held", 32'(gnt), 32'b0010);
    step();
    check("timeout pulse", 32'(timeout_err), 32'd1);
    check("timeout gnt cleared", 32'(gnt), 32'd0);
    check("timeout busy", 32'(busy), 32'd0);
    check("timeout out_valid", 32'(out_valid), 32'd0);
    step();
    check("timeout pulse width", 32'(timeout_err), 32'd0);

    grant_frame("after-timeout", 4'b0101, 4'b0000, 4'b0100, 32);
    grant_frame("drop-req3", 4'b1000, 4'b0000, 4'b1000, 8);
    grant_frame("short31", 4'b0001, 4'b0000, 4'b0001, 31);
    grant_frame("long33", 4'b0010, 4'b0000, 4'b0010, 33);
    step();
    check("final len_err", 32'(len_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
